osd_io_master: RTL
==================

OSD_IO_MASTER -- requirements
Module: osd_io_master

Interface
REQ-001 Parameter SETUP_CYC, default 1: clk_sys cycles with io_osd high and io_din valid before the first strobe.
REQ-002 Parameter HI_CYC, default 1: io_strobe high time per word, in cycles.
REQ-003 Parameter LO_CYC, default 1: io_strobe low time after each strobe, in cycles.
REQ-004 Parameter GAP_CYC, default 2: minimum io_osd-low cycles between transactions.
REQ-005 clk_sys  in  1  single clock; all logic is synchronous to it.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  host word valid.
REQ-008 cmd_ready  out  1  block accepts a word this cycle.
REQ-009 cmd_word  in  16  command or data word.
REQ-010 cmd_last  in  1  word closes the current transaction.
REQ-011 cmd_abort  in  1  terminates the current transaction immediately.
REQ-012 io_osd  out  1  transaction frame to the OSD.
REQ-013 io_strobe  out  1  word strobe; the OSD samples on its rising edge.
REQ-014 io_din  out  16  word to the OSD.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 word_cnt  out  13  words strobed in the current transaction; saturates at 8191.

Function
REQ-017 State set: IDLE, SETUP, STB_HI, STB_LO, WAIT, GAP; one shared down-counter, 4 bits wide, serves all timed states.
REQ-018 cmd_ready is high only in IDLE and WAIT, and only when cmd_abort is low.
REQ-019 A transfer occurs when cmd_valid and cmd_ready are both high; on transfer, the block registers cmd_word into io_din and cmd_last into an internal flag.
REQ-020 IDLE transfer: io_osd goes high and state goes to SETUP on the next cycle, with word_cnt cleared.
REQ-021 SETUP lasts SETUP_CYC cycles, then goes to STB_HI.
REQ-022 STB_HI drives io_strobe=1 for HI_CYC cycles, then goes to STB_LO; word_cnt increments on entry to STB_HI.
REQ-023 STB_LO drives io_strobe=0 for LO_CYC cycles; it then goes to GAP if the last flag is set, otherwise to WAIT.
REQ-024 WAIT keeps io_osd=1 and io_strobe=0; a transfer goes directly to STB_HI on the next cycle, with no SETUP.
REQ-025 GAP drives io_osd=0 and io_strobe=0 for GAP_CYC cycles, then goes to IDLE.
REQ-026 io_din changes only on a transfer and is stable through the following STB_HI and STB_LO.
REQ-027 The minimum period between strobes is HI_CYC+LO_CYC cycles, which guarantees that the OSD's one-cycle-delayed edge detector sees every rising edge.
REQ-028 cmd_abort is honoured in any non-IDLE, non-GAP state: the next cycle has io_strobe=0 and io_osd=0, state goes to GAP, and no pending word is strobed.
REQ-029 cmd_abort in IDLE or GAP has no effect.
REQ-030 cmd_abort and cmd_valid high in the same cycle: abort wins and no transfer occurs.
REQ-031 cmd_last on the first word gives a single-word transaction (e.g. OSD enable/disable command).
REQ-032 All outputs are registered; there is no combinational path from any input to io_osd, io_strobe or io_din.
REQ-033 cmd_ready is the single permitted combinational output, derived from the state and cmd_abort only.

Reset
REQ-034 Reset sets: state=IDLE, io_osd=0, io_strobe=0, io_din=0, word_cnt=0, busy=0, counter=0, last flag=0.
REQ-035 Reset asserted mid-transaction deasserts io_osd and io_strobe on the next cycle and discards the transaction; no GAP is enforced after reset.

Structure
REQ-036 Package osd_io_pkg holds the state enumeration and the default timing constants.
REQ-037 The block has no sub-modules; the FSM and the counter are written inline.

Verification
REQ-038 Defaults, single word 0x0041 with cmd_last, accepted at cycle 0 -> io_osd high cycles 1-2, io_strobe high cycle 2 only, io_din=0x0041 cycles 1-3, GAP cycles 4-5, cmd_ready high again at cycle 6.
REQ-039 Write transaction: 0x0020 then 256 data bytes, last on the 257th word, host valid every cycle -> 257 strobes exactly 2 cycles apart, word_cnt=257 at end, io_osd low for at least 2 cycles afterwards.
REQ-040 Host stalls 10 cycles between words -> block sits in WAIT, io_osd stays 1, io_strobe stays 0, io_din holds the last word, and no extra strobe is issued.
REQ-041 cmd_abort asserted during STB_HI of word 3 -> io_strobe=0 and io_osd=0 on the next cycle, GAP lasts 2 cycles, word_cnt=3, next transaction starts cleanly.
REQ-042 HI_CYC=3, LO_CYC=2, GAP_CYC=4 -> strobe high exactly 3 cycles, low 2 cycles, inter-transaction gap 4 cycles; check all timing against a cycle-accurate reference model.
REQ-043 Reset pulsed in WAIT, and cmd_abort with cmd_valid in the same cycle -> all outputs return to their REQ-034 values the next cycle, and the simultaneous word is not accepted.

Source files
------------

// File: rtl/osd_io_pkg.sv
// rtl/osd_io_pkg.sv - state encoding and default timing for the OSD I/O master
package osd_io_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STB_HI = 3'd2;
  localparam logic [2:0] ST_STB_LO = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_HI_CYC    = 1;
  localparam int DEF_LO_CYC    = 1;
  localparam int DEF_GAP_CYC   = 2;

  localparam int CNT_W      = 4;
  localparam int WORD_CNT_W = 13;

  // Down-counter load value for a state lasting cyc cycles (exit on zero).
  function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/osd_io_master.sv
// rtl/osd_io_master.sv - frames host words into io_osd/io_strobe/io_din transactions
module osd_io_master
  import osd_io_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int HI_CYC    = DEF_HI_CYC,
  parameter int LO_CYC    = DEF_LO_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [15:0]           cmd_word,
  input  logic                  cmd_last,
  input  logic                  cmd_abort,
  output logic                  io_osd,
  output logic                  io_strobe,
  output logic [15:0]           io_din,
  output logic                  busy,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  localparam logic [CNT_W-1:0] LD_SETUP   = cyc_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] LD_HI      = cyc_load(HI_CYC);
  localparam logic [CNT_W-1:0] LD_LO_LAST = cyc_load(LO_CYC);
  localparam logic [CNT_W-1:0] LD_LO_MID  = cyc_load(LO_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP     = cyc_load(GAP_CYC);

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  last_flag;
  logic                  xfer;
  logic                  cnt_done;
  logic                  abort_hit;
  logic [WORD_CNT_W-1:0] word_cnt_inc;

  assign cmd_ready    = ((state == ST_IDLE) || (state == ST_WAIT)) && !cmd_abort;
  assign xfer         = cmd_valid && cmd_ready;
  assign cnt_done     = (cnt == '0);
  assign busy         = (state != ST_IDLE);
  assign abort_hit    = cmd_abort && (state != ST_IDLE) && (state != ST_GAP);
  assign word_cnt_inc = (word_cnt == '1) ? word_cnt : word_cnt + 1'b1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_flag <= 1'b0;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
      io_din    <= '0;
      word_cnt  <= '0;
    end else if (abort_hit) begin
      state     <= ST_GAP;
      cnt       <= LD_GAP;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            state     <= ST_SETUP;
            cnt       <= LD_SETUP;
            io_osd    <= 1'b1;
            io_din    <= cmd_word;
            last_flag <= cmd_last;
            word_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            state     <= ST_STB_HI;
            cnt       <= LD_HI;
            io_strobe <= 1'b1;
            word_cnt  <= word_cnt_inc;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // A continuing word spends its final low cycle in WAIT so the next
        // word can be taken there; the last word closes the frame as the strobe falls.
        ST_STB_HI: begin
          if (cnt_done) begin
            io_strobe <= 1'b0;
            if (last_flag) begin
              state  <= ST_STB_LO;
              cnt    <= LD_LO_LAST;
              io_osd <= 1'b0;
            end else if (LO_CYC > 1) begin
              state <= ST_STB_LO;
              cnt   <= LD_LO_MID;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STB_LO: begin
          if (cnt_done) begin
            if (last_flag) begin
              state <= ST_GAP;
              cnt   <= LD_GAP;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (xfer) begin
            state     <= ST_STB_HI;
            cnt       <= LD_HI;
            io_strobe <= 1'b1;
            io_din    <= cmd_word;
            last_flag <= cmd_last;
            word_cnt  <= word_cnt_inc;
          end
        end
        ST_GAP: begin
          if (cnt_done) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          io_osd    <= 1'b0;
          io_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule
